// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared parameters, write-buffer entry and FSM state types for rf_access_ctrl
package rf_pkg;

  localparam int RF_NREGS      = 16;
  localparam int RF_WIDTH      = 16;
  localparam int RF_WBUF_DEPTH = 2;
  localparam int RF_AW         = $clog2(RF_NREGS);
  localparam int RF_IW         = $clog2(RF_WBUF_DEPTH);

  typedef struct packed {
    logic [RF_AW-1:0]    regnum;
    logic [RF_WIDTH-1:0] data;
  } wbuf_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic [RF_NREGS-1:0] onehot(input logic [RF_AW-1:0] r);
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_wbuf.sv
// rtl/rf_wbuf.sv - in-order write buffer with push/pop, occupancy count and newest-match lookup
module rf_wbuf
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [RF_AW-1:0]    push_reg,
  input  logic [RF_WIDTH-1:0] push_data,
  input  logic                pop,
  output logic [1:0]          count,
  output logic [RF_AW-1:0]    head_reg,
  output logic [RF_WIDTH-1:0] head_data,
  input  logic [RF_AW-1:0]    q1_reg,
  input  logic [RF_AW-1:0]    q2_reg,
  output logic                q1_hit,
  output logic [RF_WIDTH-1:0] q1_data,
  output logic                q2_hit,
  output logic [RF_WIDTH-1:0] q2_data
);

  wbuf_entry_t      ent [RF_WBUF_DEPTH];
  logic             pop_ok;
  logic             push_ok;
  logic [1:0]       wr_idx;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && (count < 2'(RF_WBUF_DEPTH));
  // after a pop the entries shift down, so the free slot is one lower
  assign wr_idx  = count - {1'b0, pop_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      for (int i = 0; i < RF_WBUF_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < RF_WBUF_DEPTH - 1; i++) ent[i] <= ent[i+1];
      end
      if (push_ok) ent[wr_idx[RF_IW-1:0]] <= '{regnum: push_reg, data: push_data};
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head_reg  = ent[0].regnum;
  assign head_data = ent[0].data;

  // later (newer) entries override older ones
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < RF_WBUF_DEPTH; i++) begin
      if (count > 2'(i) && ent[i].regnum == q1_reg) begin
        q1_hit  = 1'b1;
        q1_data = ent[i].data;
      end
      if (count > 2'(i) && ent[i].regnum == q2_reg) begin
        q2_hit  = 1'b1;
        q2_data = ent[i].data;
      end
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - register-file access controller; RF_BYPASS_EN selects write-buffer read bypass over read stall
module rf_access_ctrl
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_reg,
  input  logic [15:0]         wr_data,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [3:0]          rd1_reg,
  input  logic [3:0]          rd2_reg,
  output logic                rd_resp_valid,
  input  logic                rd_resp_ready,
  output logic [15:0]         rd1_data,
  output logic [15:0]         rd2_data,
  output logic [15:0]         WriteEnable,
  output logic [15:0]         WriteData,
  output logic [15:0]         ReadEnable1,
  output logic [15:0]         ReadEnable2,
  input  logic [15:0]         Bitline1,
  input  logic [15:0]         Bitline2
);

  logic [1:0]          count;
  logic [RF_AW-1:0]    head_reg;
  logic [RF_WIDTH-1:0] head_data;
  logic                hit1, hit2;
  logic [RF_WIDTH-1:0] hdata1, hdata2;
  logic                push, pop, rd_stall, rd_accept;
  logic [RF_WIDTH-1:0] sel1, sel2;
  state_t              state, state_nxt;

  assign wr_ready = !rst && (count < 2'(RF_WBUF_DEPTH));
  // register 0 writes complete the handshake but never reach the buffer
  assign push     = wr_valid && wr_ready && (wr_reg != '0);
  assign pop      = (count != 2'd0);

  rf_wbuf u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_reg  (wr_reg),
    .push_data (wr_data),
    .pop       (pop),
    .count     (count),
    .head_reg  (head_reg),
    .head_data (head_data),
    .q1_reg    (rd1_reg),
    .q2_reg    (rd2_reg),
    .q1_hit    (hit1),
    .q1_data   (hdata1),
    .q2_hit    (hit2),
    .q2_data   (hdata2)
  );

`ifdef RF_BYPASS_EN
  assign rd_stall = 1'b0;
`else
  // reads of a register with a pending write wait until it reaches the array
  assign rd_stall = ((rd1_reg != '0) && hit1) || ((rd2_reg != '0) && hit2);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rd_ready      = 1'b0;
    rd_resp_valid = 1'b0;
    rd_accept     = 1'b0;
    case (state)
      IDLE: begin
        rd_ready  = !rst && !rd_stall;
        rd_accept = rd_valid && rd_ready;
        if (rd_accept) state_nxt = RESP;
      end
      RESP: begin
        rd_resp_valid = !rst;
        if (rd_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ReadEnable1 = (rd_accept && rd1_reg != '0) ? onehot(rd1_reg) : '0;
  assign ReadEnable2 = (rd_accept && rd2_reg != '0) ? onehot(rd2_reg) : '0;
  assign WriteEnable = (pop && !rst) ? onehot(head_reg) : '0;
  assign WriteData   = pop ? head_data : '0;

  // a hit can only reach this mux in the bypass build; otherwise the read stalls
  assign sel1 = (rd1_reg == '0) ? '0 : (hit1 ? hdata1 : Bitline1);
  assign sel2 = (rd2_reg == '0) ? '0 : (hit2 ? hdata2 : Bitline2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_data <= '0;
      rd2_data <= '0;
    end else if (rd_accept) begin
      rd1_data <= sel1;
      rd2_data <= sel2;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb/tb_rf_access_ctrl.sv - directed self-checking bench for rf_access_ctrl
module tb_rf_access_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd1_reg, rd2_reg;
  logic        rd_resp_valid, rd_resp_ready;
  logic [15:0] rd1_data, rd2_data;
  logic [15:0] WriteEnable, WriteData, ReadEnable1, ReadEnable2;
  logic [15:0] Bitline1, Bitline2;

  int n_cmp = 0;
  int n_bad = 0;

  rf_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd1_reg       (rd1_reg),
    .rd2_reg       (rd2_reg),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd1_data      (rd1_data),
    .rd2_data      (rd2_data),
    .WriteEnable   (WriteEnable),
    .WriteData     (WriteData),
    .ReadEnable1   (ReadEnable1),
    .ReadEnable2   (ReadEnable2),
    .Bitline1      (Bitline1),
    .Bitline2      (Bitline2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_reg = 4'd0; wr_data = 16'h0;
    rd_valid = 1'b0; rd1_reg = 4'd0; rd2_reg = 4'd0;
    rd_resp_ready = 1'b0; Bitline1 = 16'h0; Bitline2 = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_reg = 4'd3; wr_data = 16'h1234;
    rd_valid = 1'b1; rd1_reg = 4'd3; rd2_reg = 4'd4;
    tick(); tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %h want 0", wr_ready); end
    n_cmp++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rd_ready: got %h want 0", rd_ready); end
    n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %h want 0", rd_resp_valid); end
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL rst_we: got %h want 0000", WriteEnable); end
    n_cmp++; if ({ReadEnable1, ReadEnable2} !== 32'h0) begin n_bad++; $display("FAIL rst_re: got %h/%h want 0000/0000", ReadEnable1, ReadEnable2); end
    rst = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rel_wr_ready: got %h want 1", wr_ready); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_rd_ready: got %h want 1", rd_ready); end
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL rel_we: got %h want 0000", WriteEnable); end
    tick();
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_reg = 4'd3; wr_data = 16'hBEEF;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %h want 1", wr_ready); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (WriteEnable !== 16'h0008) begin n_bad++; $display("FAIL wr_we: got %h want 0008", WriteEnable); end
    n_cmp++; if (WriteData !== 16'hBEEF) begin n_bad++; $display("FAIL wr_wd: got %h want beef", WriteData); end
    tick();
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL wr_we_drained: got %h want 0000", WriteEnable); end
    rd_valid = 1'b1; rd1_reg = 4'd3; rd2_reg = 4'd0; Bitline1 = 16'hBEEF; Bitline2 = 16'h1234;
    #1;
    n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %h want 1", rd_ready); end
    n_cmp++; if (ReadEnable1 !== 16'h0008) begin n_bad++; $display("FAIL rd_re1: got %h want 0008", ReadEnable1); end
    n_cmp++; if (ReadEnable2 !== 16'h0) begin n_bad++; $display("FAIL rd_re2_reg0: got %h want 0000", ReadEnable2); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %h want 1", rd_resp_valid); end
    n_cmp++; if (rd1_data !== 16'hBEEF) begin n_bad++; $display("FAIL rd1_data: got %h want beef", rd1_data); end
    n_cmp++; if (rd2_data !== 16'h0) begin n_bad++; $display("FAIL rd2_data_reg0: got %h want 0000", rd2_data); end
    n_cmp++; if (ReadEnable1 !== 16'h0) begin n_bad++; $display("FAIL rd_re1_after: got %h want 0000", ReadEnable1); end
    rd_resp_ready = 1'b1;
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_done: got %h want 0", rd_resp_valid); end
    n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready_done: got %h want 1", rd_ready); end
  endtask

  task automatic test_full_buffer();
    wr_valid = 1'b1; wr_reg = 4'd1; wr_data = 16'h1111; #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fb_rdy1: got %h want 1", wr_ready); end
    tick();
    wr_reg = 4'd2; wr_data = 16'h2222; #1;
    n_cmp++; if (WriteEnable !== 16'h0002 || WriteData !== 16'h1111) begin n_bad++; $display("FAIL fb_drain1: got %h/%h want 0002/1111", WriteEnable, WriteData); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fb_rdy2: got %h want 1", wr_ready); end
    tick();
    wr_reg = 4'd5; wr_data = 16'h5555; #1;
    n_cmp++; if (WriteEnable !== 16'h0004 || WriteData !== 16'h2222) begin n_bad++; $display("FAIL fb_drain2: got %h/%h want 0004/2222", WriteEnable, WriteData); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fb_rdy3: got %h want 1", wr_ready); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (WriteEnable !== 16'h0020 || WriteData !== 16'h5555) begin n_bad++; $display("FAIL fb_drain3: got %h/%h want 0020/5555", WriteEnable, WriteData); end
    tick();
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL fb_empty: got %h want 0000", WriteEnable); end
  endtask

  task automatic test_reg_zero();
    wr_valid = 1'b1; wr_reg = 4'd0; wr_data = 16'h1234; #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL z_wr_ready: got %h want 1", wr_ready); end
    tick();
    idle_inputs();
    rd_valid = 1'b1; rd1_reg = 4'd0; rd2_reg = 4'd0; Bitline1 = 16'hFFFF; Bitline2 = 16'hFFFF; #1;
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL z_we: got %h want 0000", WriteEnable); end
    n_cmp++; if ({ReadEnable1, ReadEnable2} !== 32'h0) begin n_bad++; $display("FAIL z_re: got %h/%h want 0000/0000", ReadEnable1, ReadEnable2); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b1 || rd1_data !== 16'h0 || rd2_data !== 16'h0) begin n_bad++; $display("FAIL z_data: got %h %h/%h want 1 0000/0000", rd_resp_valid, rd1_data, rd2_data); end
    rd_resp_ready = 1'b1; tick(); idle_inputs();
  endtask

  task automatic test_bypass();
    wr_valid = 1'b1; wr_reg = 4'd7; wr_data = 16'h00A5;
    tick();
    idle_inputs();
    rd_valid = 1'b1; rd1_reg = 4'd7; rd2_reg = 4'd7; Bitline1 = 16'hFFFF; Bitline2 = 16'hFFFF; #1;
`ifdef RF_BYPASS_EN
    n_cmp++; if (rd_ready !== 1'b1 || ReadEnable1 !== 16'h0080) begin n_bad++; $display("FAIL bp_accept: got %h/%h want 1/0080", rd_ready, ReadEnable1); end
    tick();
`else
    n_cmp++; if (rd_ready !== 1'b0 || ReadEnable1 !== 16'h0) begin n_bad++; $display("FAIL bp_stall: got %h/%h want 0/0000", rd_ready, ReadEnable1); end
    n_cmp++; if (WriteEnable !== 16'h0080) begin n_bad++; $display("FAIL bp_drain: got %h want 0080", WriteEnable); end
    tick();
    Bitline1 = 16'h00A5; Bitline2 = 16'h00A5; #1;
    n_cmp++; if (rd_ready !== 1'b1 || ReadEnable1 !== 16'h0080 || ReadEnable2 !== 16'h0080) begin n_bad++; $display("FAIL bp_release: got %h/%h/%h want 1/0080/0080", rd_ready, ReadEnable1, ReadEnable2); end
    tick();
`endif
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b1 || rd1_data !== 16'h00A5 || rd2_data !== 16'h00A5) begin n_bad++; $display("FAIL bp_data: got %h %h/%h want 1 00a5/00a5", rd_resp_valid, rd1_data, rd2_data); end
    rd_resp_ready = 1'b1; tick(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    wr_valid = 1'b1; wr_reg = 4'd6; wr_data = 16'hDEAD;
    rd_valid = 1'b1; rd1_reg = 4'd6; rd2_reg = 4'd9; Bitline1 = 16'h0606; Bitline2 = 16'h0909; #1;
    n_cmp++; if (rd_ready !== 1'b1 || ReadEnable2 !== 16'h0200) begin n_bad++; $display("FAIL bb_accept: got %h/%h want 1/0200", rd_ready, ReadEnable2); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd1_data !== 16'h0606 || rd2_data !== 16'h0909) begin n_bad++; $display("FAIL bb_no_fwd: got %h/%h want 0606/0909", rd1_data, rd2_data); end
    n_cmp++; if (WriteEnable !== 16'h0040 || WriteData !== 16'hDEAD) begin n_bad++; $display("FAIL bb_we: got %h/%h want 0040/dead", WriteEnable, WriteData); end
    rd_resp_ready = 1'b1; tick(); idle_inputs();
  endtask

  task automatic test_backpressure();
    rd_valid = 1'b1; rd1_reg = 4'd4; rd2_reg = 4'd9; Bitline1 = 16'h4444; Bitline2 = 16'h9999;
    tick();
    Bitline1 = 16'h0; Bitline2 = 16'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (rd_resp_valid !== 1'b1 || rd1_data !== 16'h4444 || rd2_data !== 16'h9999) begin n_bad++; $display("FAIL bkp_hold%0d: got %h %h/%h want 1 4444/9999", i, rd_resp_valid, rd1_data, rd2_data); end
      n_cmp++; if (rd_ready !== 1'b0 || ReadEnable1 !== 16'h0) begin n_bad++; $display("FAIL bkp_busy%0d: got %h/%h want 0/0000", i, rd_ready, ReadEnable1); end
      tick();
    end
    rd_valid = 1'b0; rd_resp_ready = 1'b1; #1;
    n_cmp++; if (rd_resp_valid !== 1'b1) begin n_bad++; $display("FAIL bkp_last: got %h want 1", rd_resp_valid); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b0 || rd_ready !== 1'b1) begin n_bad++; $display("FAIL bkp_idle: got %h/%h want 0/1", rd_resp_valid, rd_ready); end
  endtask

  task automatic test_reset_mid();
    wr_valid = 1'b1; wr_reg = 4'd1; wr_data = 16'hAAAA;
    rd_valid = 1'b1; rd1_reg = 4'd2; rd2_reg = 4'd3; Bitline1 = 16'h2222; Bitline2 = 16'h3333;
    tick();
    rd_valid = 1'b0; wr_reg = 4'd2; wr_data = 16'hBBBB;
    tick();
    idle_inputs(); #1;
    n_cmp++; if (rd_resp_valid !== 1'b1 || WriteEnable !== 16'h0004) begin n_bad++; $display("FAIL rm_pre: got %h/%h want 1/0004", rd_resp_valid, WriteEnable); end
    rst = 1'b1; wr_valid = 1'b1; wr_reg = 4'd8; #1;
    n_cmp++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0 || WriteEnable !== 16'h0) begin n_bad++; $display("FAIL rm_during: got %h/%h/%h want 0/0/0000", wr_ready, rd_ready, WriteEnable); end
    tick();
    rst = 1'b0; idle_inputs(); #1;
    n_cmp++; if (WriteEnable !== 16'h0 || rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_after: got %h/%h want 0000/0", WriteEnable, rd_resp_valid); end
    n_cmp++; if (rd1_data !== 16'h0 || rd2_data !== 16'h0) begin n_bad++; $display("FAIL rm_data: got %h/%h want 0000/0000", rd1_data, rd2_data); end
    n_cmp++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %h/%h want 1/1", wr_ready, rd_ready); end
    tick();
    n_cmp++; if (WriteEnable !== 16'h0) begin n_bad++; $display("FAIL rm_empty: got %h want 0000", WriteEnable); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_full_buffer();
    test_reg_zero();
    test_bypass();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
